// File: rtl/device_b_pkg.sv
// Shared definitions for the device_b SPI responder: FSM states, default width
// and the SPI mode it implements.
package device_b_pkg;

  localparam int DATA_W_DEF = 32;

  // Mode 0: sclk idles low, data is captured on the rising edge.
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_CMD    = 3'd1,
    CMD_HS    = 3'd2,
    WAIT_RESP = 3'd3,
    READY     = 3'd4,
    TX_RESP   = 3'd5,
    DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/device_b_if.sv
// Local-logic side of device_b: command hand-off, response capture and status.
interface device_b_if
  import device_b_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_valid;
  logic              response_ready;
  logic              busy;

  modport slave (
    output cmd_data, cmd_valid, response_ready, busy,
    input  cmd_ready, resp_data, resp_valid
  );

  modport master (
    input  cmd_data, cmd_valid, response_ready, busy,
    output cmd_ready, resp_data, resp_valid
  );
endinterface

// File: rtl/device_b_spi_in_sync.sv
// Synchronizes the asynchronous SPI pins into clk and produces registered
// single-cycle sclk rise/fall pulses aligned with the synchronized mosi.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic mosi_s,
  output logic cs_n_s,
  output logic sclk_rise,
  output logic sclk_fall
);
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic                   sclk_d;

  // cs_n chain clears to its inactive (high) level so reset never looks like a select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q    <= '0;
      mosi_q    <= '0;
      cs_q      <= '1;
      sclk_d    <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
      cs_q      <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sclk_d    <= sclk_q[SYNC_STAGES-1];
      sclk_rise <= sclk_q[SYNC_STAGES-1] & ~sclk_d;
      sclk_fall <= ~sclk_q[SYNC_STAGES-1] & sclk_d;
      mosi_s    <= mosi_q[SYNC_STAGES-1];
    end
  end

  assign cs_n_s = cs_q[SYNC_STAGES-1];

endmodule

// File: rtl/device_b.sv
// SPI responder: receives a command word, hands it to local logic, then shifts
// the local response back out on miso while the master keeps cs_n low.
module device_b
  import device_b_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  device_b_if.slave   lbus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] shift_in, shift_in_nx;
  logic [DATA_W-1:0] tx_shift, tx_shift_nx;
  logic [DATA_W-1:0] cmd_data, cmd_data_nx;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic              cmd_valid, cmd_valid_nx;
  logic              resp_rdy, resp_rdy_nx;
  logic              miso_nx;
  logic              mosi_s, cs_n_s, sclk_rise, sclk_fall;
  logic              capture, launch, abort;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .mosi_s    (mosi_s),
    .cs_n_s    (cs_n_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  assign capture = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
  assign launch  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;
  // Deselect mid-transaction; in DONE a rising cs_n is the normal exit.
  assign abort   = cs_n_s && (state != IDLE) && (state != DONE);

  always_comb begin
    state_nx     = state;
    shift_in_nx  = shift_in;
    tx_shift_nx  = tx_shift;
    cmd_data_nx  = cmd_data;
    bit_cnt_nx   = bit_cnt;
    cmd_valid_nx = cmd_valid;
    resp_rdy_nx  = resp_rdy;
    miso_nx      = miso;
    if (abort) begin
      state_nx     = IDLE;
      cmd_valid_nx = 1'b0;
      resp_rdy_nx  = 1'b0;
      miso_nx      = 1'b0;
      bit_cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          miso_nx    = 1'b0;
          bit_cnt_nx = '0;
          if (!cs_n_s) state_nx = RX_CMD;
        end
        RX_CMD: begin
          if (capture) begin
            shift_in_nx = {shift_in[DATA_W-2:0], mosi_s};
            bit_cnt_nx  = bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              cmd_data_nx  = shift_in_nx;
              cmd_valid_nx = 1'b1;
              state_nx     = CMD_HS;
            end
          end
        end
        CMD_HS: begin
          if (lbus.cmd_ready) begin
            cmd_valid_nx = 1'b0;
            state_nx     = WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (lbus.resp_valid) begin
            tx_shift_nx = lbus.resp_data;
            miso_nx     = lbus.resp_data[DATA_W-1];
            resp_rdy_nx = 1'b1;
            state_nx    = READY;
          end
        end
        READY: begin
          // The MSB is already on miso, so this first capture edge is bit 1.
          if (capture) begin
            resp_rdy_nx = 1'b0;
            bit_cnt_nx  = CNT_W'(1);
            state_nx    = TX_RESP;
          end
        end
        TX_RESP: begin
          if (launch) begin
            tx_shift_nx = {tx_shift[DATA_W-2:0], 1'b0};
            miso_nx     = tx_shift[DATA_W-2];
          end
          if (capture) begin
            bit_cnt_nx = bit_cnt + 1'b1;
            if (bit_cnt_nx == CNT_W'(DATA_W)) state_nx = DONE;
          end
        end
        DONE: begin
          miso_nx = 1'b0;
          if (cs_n_s) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_in  <= '0;
      tx_shift  <= '0;
      cmd_data  <= '0;
      bit_cnt   <= '0;
      cmd_valid <= 1'b0;
      resp_rdy  <= 1'b0;
      miso      <= 1'b0;
    end else begin
      state     <= state_nx;
      shift_in  <= shift_in_nx;
      tx_shift  <= tx_shift_nx;
      cmd_data  <= cmd_data_nx;
      bit_cnt   <= bit_cnt_nx;
      cmd_valid <= cmd_valid_nx;
      resp_rdy  <= resp_rdy_nx;
      miso      <= miso_nx;
    end
  end

  assign lbus.cmd_data       = cmd_data;
  assign lbus.cmd_valid      = cmd_valid;
  assign lbus.response_ready = resp_rdy;
  assign lbus.busy           = (state != IDLE);

endmodule

// File: tb/tb_device_b.sv
// Scoreboard bench for device_b: an SPI master model drives exchanges, and
// monitors compare handed-off commands and shifted-out responses to queues.
module tb_device_b;
  localparam int DW = 32;
  localparam int S  = 2;
  localparam int H  = 6;

  logic clk, rst, sclk, mosi, cs_n, miso;
  logic ph2;
  int   n_checks, n_pass;
  logic [DW-1:0] exp_cmd_q[$];
  logic [DW-1:0] exp_rsp_q[$];
  logic [DW-1:0] rx_word;
  int            rx_n;

  device_b_if #(.DATA_W(DW)) bus ();

  device_b #(.DATA_W(DW), .SYNC_STAGES(S)) dut (
    .clk  (clk),
    .rst  (rst),
    .sclk (sclk),
    .mosi (mosi),
    .cs_n (cs_n),
    .miso (miso),
    .lbus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Command hand-off monitor: every accepted command must match the next one sent.
  always @(negedge clk) begin
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      if (exp_cmd_q.size() == 0) begin
        n_checks++;
        $display("FAIL cmd_unexpected: got 0x%08h with no command outstanding", bus.cmd_data);
      end else begin
        chk("cmd_data", bus.cmd_data, exp_cmd_q.pop_front());
      end
    end
  end

  // Response monitor: what the master samples on miso over 32 phase-2 edges.
  initial begin
    rx_n = 0;
    rx_word = '0;
    forever begin
      @(posedge sclk or negedge ph2);
      if (!ph2) rx_n = 0;
      else if (!cs_n) begin
        rx_word = {rx_word[DW-2:0], miso};
        rx_n++;
        if (rx_n == DW) begin
          rx_n = 0;
          if (exp_rsp_q.size() == 0) begin
            n_checks++;
            $display("FAIL resp_unexpected: got 0x%08h with no response outstanding", rx_word);
          end else begin
            chk("resp_word", rx_word, exp_rsp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spi_bit(input logic b, input bit lat, output logic r);
    mosi = b;
    tick(H);
    sclk = 1'b1;
    r = miso;
    if (lat) begin
      tick(S + 1);
      chk("cmd_valid_early", bus.cmd_valid, 0);
      tick(1);
      chk("cmd_valid_latency", bus.cmd_valid, 1);
      tick(H - S - 2);
    end else begin
      tick(H);
    end
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [DW-1:0] w, input int nbits, input bit lat);
    logic r;
    cs_n = 1'b0;
    tick(2);
    for (int i = DW - 1; i >= DW - nbits; i--) spi_bit(w[i], lat && (i == 0), r);
  endtask

  task automatic accept_cmd();
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
  endtask

  task automatic give_resp(input logic [DW-1:0] rsp, input int dly);
    tick(dly);
    bus.resp_data  = rsp;
    bus.resp_valid = 1'b1;
    tick(1);
    bus.resp_valid = 1'b0;
    chk("response_ready_latency", bus.response_ready, 1);
    chk("miso_msb_preload", miso, rsp[DW-1]);
  endtask

  task automatic phase2(input logic [DW-1:0] rsp, input int stop_after);
    logic r;
    exp_rsp_q.push_back(rsp);
    mosi = 1'b0;
    ph2  = 1'b1;
    for (int i = 0; i < stop_after; i++) begin
      spi_bit(1'b0, 1'b0, r);
      if (i == 0) chk("response_ready_drop", bus.response_ready, 0);
    end
  endtask

  task automatic finish_cs();
    cs_n = 1'b1;
    ph2  = 1'b0;
    tick(S + 2);
    chk("busy_after_cs_high", bus.busy, 0);
  endtask

  task automatic exchange(input logic [DW-1:0] c, input logic [DW-1:0] rsp, input int dly);
    exp_cmd_q.push_back(c);
    send_bits(c, DW, 1'b0);
    accept_cmd();
    give_resp(rsp, dly);
    phase2(rsp, DW);
    tick(2);
    chk("miso_done_zero", miso, 0);
    chk("busy_in_done", bus.busy, 1);
    finish_cs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    cs_n = 1'b1;
    ph2  = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    tick(3);
    chk("reset_miso", miso, 0);
    chk("reset_response_ready", bus.response_ready, 0);
    chk("reset_cmd_data", bus.cmd_data, 0);
    chk("reset_cmd_valid", bus.cmd_valid, 0);
    chk("reset_busy", bus.busy, 0);
    rst = 1'b0;
    tick(3);

    // Command receive with a held-off handshake.
    exp_cmd_q.push_back(32'hA5A5_1234);
    send_bits(32'hA5A5_1234, DW, 1'b1);
    chk("cmd_data_direct", bus.cmd_data, 32'hA5A5_1234);
    tick(5);
    chk("cmd_valid_held", bus.cmd_valid, 1);
    chk("busy_cmd_hs", bus.busy, 1);
    accept_cmd();
    chk("cmd_valid_cleared", bus.cmd_valid, 0);
    give_resp(32'h1234_5678, 3);
    phase2(32'h1234_5678, DW);
    finish_cs();

    // Full exchanges, including MSB/LSB boundaries.
    exchange(32'h0000_00FF, 32'hDEAD_BEEF, 10);
    exchange(32'h0000_0000, 32'h8000_0001, 2);

    // Abort after 17 command bits, then a clean transaction.
    send_bits($urandom(), 17, 1'b0);
    cs_n = 1'b1;
    tick(S + 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cmd_valid", bus.cmd_valid, 0);
    tick(2);
    exchange(32'h1357_9BDF, $urandom(), 4);

    // Abort while the response is loaded.
    exp_cmd_q.push_back(32'h0F0F_0F0F);
    send_bits(32'h0F0F_0F0F, DW, 1'b0);
    accept_cmd();
    give_resp(32'hF000_0000, 1);
    cs_n = 1'b1;
    tick(S + 1);
    chk("ready_abort_response_ready", bus.response_ready, 0);
    chk("ready_abort_miso", miso, 0);
    chk("ready_abort_busy", bus.busy, 0);
    chk("ready_abort_cmd_data_kept", bus.cmd_data, 32'h0F0F_0F0F);
    bus.resp_data  = 32'hFFFF_FFFF;
    bus.resp_valid = 1'b1;
    tick(1);
    bus.resp_valid = 1'b0;
    tick(1);
    chk("ignored_resp_valid_rr", bus.response_ready, 0);
    chk("ignored_resp_valid_miso", miso, 0);

    // Asynchronous reset in the middle of phase 2.
    exp_cmd_q.push_back(32'h0000_0005);
    send_bits(32'h0000_0005, DW, 1'b0);
    accept_cmd();
    give_resp(32'hFFFF_FFFF, 0);
    phase2(32'hFFFF_FFFF, 9);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_miso", miso, 0);
    chk("midreset_response_ready", bus.response_ready, 0);
    chk("midreset_cmd_data", bus.cmd_data, 0);
    chk("midreset_cmd_valid", bus.cmd_valid, 0);
    chk("midreset_busy", bus.busy, 0);
    exp_rsp_q.delete();
    ph2  = 1'b0;
    cs_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    exchange(32'h0000_0001, 32'h0000_0002, 1);

    // Randomized exchanges.
    for (int k = 0; k < 4; k++) exchange($urandom(), $urandom(), $urandom_range(0, 15));

    tick(4);
    chk("cmd_queue_drained", exp_cmd_q.size(), 0);
    chk("resp_queue_drained", exp_rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
